// File: rtl/counter_sequencer.sv
// Command sequencer for an up/down loadable counter: runs CLEAR/LOAD/UP n/DOWN n
// cycle-exactly over the counter controls and reports the resulting count with status.
module counter_sequencer #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [WIDTH-1:0]  cmd_data,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              abort,
  input  logic [WIDTH-1:0]  count_out,
  output logic              load_n,
  output logic              ce,
  output logic              up_down,
  output logic [WIDTH-1:0]  data_load,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              wrapped,
  output logic              aborted,
  output logic              busy
);

  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_UP   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_CAPTURE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_is_count;
  logic [STEP_W-1:0]   r_steps;
  logic                r_wrap_flag;
  logic                r_abort_flag;
  logic                r_up_down;
  logic [WIDTH-1:0]    r_data_load;
  logic                r_done;
  logic [WIDTH-1:0]    r_result;
  logic                r_wrapped;
  logic                r_aborted;
  logic                w_accept;
  logic                w_wrap_hit;
  logic                w_load_n;
  logic                w_ce;

  assign w_accept   = cmd_valid && (r_state == S_IDLE);
  assign w_wrap_hit = r_up_down ? (count_out == {WIDTH{1'b1}}) : (count_out == '0);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next state and counter controls; abort kills ce within the same cycle
  always_comb begin
    w_next   = r_state;
    w_load_n = 1'b1;
    w_ce     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_next = (cmd_op[1] && (cmd_steps == '0)) ? S_CAPTURE : S_DRIVE;
      end
      S_DRIVE: begin
        if (!r_is_count) begin
          w_load_n = 1'b0;
          w_next   = S_CAPTURE;
        end else if (abort) begin
          w_next = S_CAPTURE;
        end else begin
          w_ce = 1'b1;
          if (r_steps == STEP_W'(1)) w_next = S_CAPTURE;
        end
      end
      S_CAPTURE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Command latch, step tracking, status and result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_is_count   <= 1'b0;
      r_steps      <= '0;
      r_wrap_flag  <= 1'b0;
      r_abort_flag <= 1'b0;
      r_up_down    <= 1'b0;
      r_data_load  <= '0;
      r_done       <= 1'b0;
      r_result     <= '0;
      r_wrapped    <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_done <= (r_state == S_CAPTURE);
      if (w_accept) begin
        r_is_count   <= cmd_op[1];
        r_steps      <= cmd_steps;
        r_wrap_flag  <= 1'b0;
        r_abort_flag <= 1'b0;
        r_wrapped    <= 1'b0;
        r_aborted    <= 1'b0;
        if (!cmd_op[1])
          r_data_load <= (cmd_op == OP_LOAD) ? cmd_data : '0;
        else if (cmd_steps != '0)
          r_up_down <= (cmd_op == OP_UP);
      end
      if ((r_state == S_DRIVE) && r_is_count) begin
        if (abort) begin
          r_abort_flag <= 1'b1;
        end else begin
          r_steps <= r_steps - STEP_W'(1);
          if (w_wrap_hit) r_wrap_flag <= 1'b1;
        end
      end
      if (r_state == S_CAPTURE) begin
        r_result  <= count_out;
        r_wrapped <= r_wrap_flag;
        r_aborted <= r_abort_flag;
      end
    end
  end

  assign cmd_ready = rst && (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign load_n    = w_load_n;
  assign ce        = w_ce;
  assign up_down   = r_up_down;
  assign data_load = r_data_load;
  assign done      = r_done;
  assign result    = r_result;
  assign wrapped   = r_wrapped;
  assign aborted   = r_aborted;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: behavioural counter, command model and
// a scoreboard of expected responses popped on each done pulse.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [3:0] cmd_data = 4'd0;
  logic [7:0] cmd_steps = 8'd0;
  logic       abort = 1'b0;
  logic [3:0] count_out;
  logic       load_n, ce, up_down, done, wrapped, aborted, busy;
  logic [3:0] data_load, result;

  typedef struct packed {
    logic [3:0] res;
    logic       wr;
    logic       ab;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   ref_val = 0;
  logic [3:0] cnt = 4'd0;

  counter_sequencer #(.WIDTH(4), .STEP_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_steps(cmd_steps), .abort(abort),
    .count_out(count_out), .load_n(load_n), .ce(ce), .up_down(up_down),
    .data_load(data_load), .done(done), .result(result), .wrapped(wrapped),
    .aborted(aborted), .busy(busy)
  );

  always #5 clk = ~clk;

  // Counter being controlled: load beats enable, wraps modulo 16
  always @(posedge clk) begin
    if (!load_n)  cnt <= data_load;
    else if (ce)  cnt <= up_down ? cnt + 4'd1 : cnt - 4'd1;
  end
  assign count_out = cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one command, model its response, and follow it to done
  task automatic do_cmd(input logic [1:0] op, input logic [3:0] data, input int steps,
                        input int abort_at, input bit b2b);
    int   e, lat, exp_ce, exp_ld, ce_cnt, ld_cnt, ud_bad, j, t, sum;
    bit   got, acc;
    logic [3:0] ld_val;
    exp_t x;
    if (op < 2'd2) begin
      x.res = (op == 2'd1) ? data : 4'd0;
      x.wr = 1'b0; x.ab = 1'b0;
      lat = 3; exp_ce = 0; exp_ld = 1;
    end else begin
      e = steps; x.ab = 1'b0;
      if (abort_at > 0 && abort_at <= steps) begin
        e = abort_at - 1; x.ab = 1'b1;
      end
      lat = (steps == 0) ? 2 : (x.ab ? abort_at + 2 : steps + 2);
      exp_ce = e; exp_ld = 0;
      if (op == 2'd2) begin
        sum = ref_val + e;
        x.wr = (sum >= 16);
      end else begin
        sum = ref_val - e + 256;
        x.wr = (e > ref_val);
      end
      x.res = 4'(sum % 16);
    end
    ref_val = int'(x.res);
    sb_q.push_back(x);

    if (!b2b) begin @(posedge clk); #1; end
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_steps = 8'(steps);
    if (!b2b) @(negedge clk);
    acc = 1'b0;
    for (t = 0; t < 20; t++) begin
      if (cmd_ready) begin acc = 1'b1; break; end
      @(negedge clk);
    end
    chk("accept", 32'(acc), 32'd1);
    if (b2b) chk("b2b_accept_cycle", 32'(t), 32'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;

    ce_cnt = 0; ld_cnt = 0; ud_bad = 0; ld_val = 4'd0; got = 1'b0; j = 1;
    while (!got && j <= lat + 6) begin
      abort = (j == abort_at);
      @(negedge clk);
      if (ce) begin
        ce_cnt++;
        if (up_down !== (op == 2'd2)) ud_bad++;
      end
      if (!load_n) begin ld_cnt++; ld_val = data_load; end
      if (done) begin
        got = 1'b1;
        chk("latency", 32'(j), 32'(lat));
        chk("ready_in_done", 32'(cmd_ready), 32'd1);
        if (sb_q.size() == 0) chk("sb_empty", 32'd0, 32'd1);
        else begin
          x = sb_q.pop_front();
          chk("result", 32'(result), 32'(x.res));
          chk("wrapped", 32'(wrapped), 32'(x.wr));
          chk("aborted", 32'(aborted), 32'(x.ab));
        end
      end else begin
        @(posedge clk); #1;
        j++;
      end
    end
    abort = 1'b0;
    if (!got) chk("done_timeout", 32'd0, 32'd1);
    chk("ce_cycles", 32'(ce_cnt), 32'(exp_ce));
    chk("load_cycles", 32'(ld_cnt), 32'(exp_ld));
    if (exp_ld != 0) chk("data_load", 32'(ld_val), 32'((op == 2'd1) ? data : 4'd0));
    chk("dir_bad", 32'(ud_bad), 32'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd0);
    chk({tag, "_load_n"}, 32'(load_n), 32'd1);
    chk({tag, "_ce"}, 32'(ce), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_flags"}, {30'd0, wrapped, aborted}, 32'd0);
    chk({tag, "_updown"}, 32'(up_down), 32'd0);
    chk({tag, "_dload"}, 32'(data_load), 32'd0);
  endtask

  initial begin
    int dn;
    #1;
    chk_reset_outs("por");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    do_cmd(2'd1, 4'hA, 0, 0, 1'b0);
    // Reset while idle clears the captured response immediately
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_outs("idle_rst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst2", 32'(cmd_ready), 32'd1);

    do_cmd(2'd1, 4'hE, 0, 0, 1'b0);
    do_cmd(2'd2, 4'h0, 5, 0, 1'b0);
    do_cmd(2'd1, 4'h7, 0, 0, 1'b0);
    do_cmd(2'd3, 4'h0, 0, 0, 1'b0);
    do_cmd(2'd1, 4'h2, 0, 0, 1'b0);
    do_cmd(2'd2, 4'h0, 200, 11, 1'b0);
    do_cmd(2'd0, 4'h9, 0, 0, 1'b1);
    do_cmd(2'd1, 4'h3, 0, 1, 1'b0);
    do_cmd(2'd3, 4'h0, 4, 0, 1'b0);
    do_cmd(2'd2, 4'h0, 255, 0, 1'b0);
    do_cmd(2'd2, 4'h0, 1, 0, 1'b0);
    do_cmd(2'd1, 4'h9, 0, 0, 1'b0);

    // Reset in the third enable cycle of DOWN 8 abandons the command
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_steps = 8'd8;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ce_before_rst", 32'(ce), 32'd1);
    rst = 1'b0;
    #1;
    chk_reset_outs("mid_rst");
    dn = 0;
    repeat (3) begin @(negedge clk); if (done) dn++; end
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst3", 32'(cmd_ready), 32'd1);
    repeat (4) begin if (done) dn++; @(negedge clk); end
    chk("no_done_after_rst", 32'(dn), 32'd0);
    ref_val = 7;
    do_cmd(2'd1, 4'h5, 0, 0, 1'b0);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
